id_stage_pipelined: RTL and testbench
=====================================

// Module: id_stage_pipelined
// PURPOSE
//  Registered MIPS instruction-decode stage: decodes the IF/ID instruction, reads
//  the register file (with WB write-through bypass), sign-extends the immediate and
//  registers everything into the ID/EX pipeline register. Detects load-use hazards,
//  stalls IF/ID and injects bubbles. Sits between instruction fetch and execute.
// PARAMETERS
//  B     32  data/instruction word width (instruction fields assume B=32)
//  W     5   register address width; register file depth = 2**W
//  IMM   16  immediate field width, sign-extended to B
// PORTS
//  clk             in   1   rising-edge clock
//  reset           in   1   asynchronous, active-high reset
//  in_valid        in   1   IF/ID holds a valid instruction
//  instruction     in   B   IF/ID instruction word
//  flush           in   1   squash instruction entering ID/EX (branch taken)
//  wb_reg_write    in   1   WB write enable
//  wb_addr         in   W   WB destination register
//  wb_data         in   B   WB write data
//  stall_out       out  1   comb.: hold PC and IF/ID this cycle
//  out_valid       out  1   ID/EX holds a valid instruction
//  reg_data1/2     out  B   rs/rt operand values
//  imm_ext         out  B   sign-extended instruction[IMM-1:0]
//  rs/rt/rd        out  W   instruction[25:21]/[20:16]/[15:11]
//  wb_reg_write_o, wb_mem_to_reg_o, m_branch_o, m_mem_read_o, m_mem_write_o,
//  ex_reg_dst_o, ex_alu_src_o   out 1 each   control bits
//  ex_alu_op_o     out  2   00 add, 01 sub(beq), 10 funct-decoded
//  illegal_o       out  1   valid instruction had an unsupported opcode
// BEHAVIOUR
//  - Reset: every ID/EX output and every register-file entry = 0; stall_out = 0.
//  - Latency 1 cycle: operands/controls for instruction at posedge N visible after N.
//  - Decode (opcode [31:26]): 000000 R-type: RegWrite,RegDst,ALUOp=10;
//    100011 lw: RegWrite,MemtoReg,MemRead,ALUSrc,ALUOp=00; 101011 sw: MemWrite,
//    ALUSrc,ALUOp=00; 000100 beq: Branch,ALUOp=01; 001000 addi: RegWrite,ALUSrc,
//    ALUOp=00. Any other opcode: all controls 0, illegal_o=1 (with out_valid=1).
//  - Register file: 2**W x B. Write on posedge when wb_reg_write && wb_addr!=0.
//    Register 0 always reads 0. Read addr == wb_addr (nonzero, write enabled) in
//    the same cycle returns wb_data (write-through bypass).
//  - Hazard: stall_out = in_valid & out_valid & m_mem_read_o & (rt_o!=0) &
//    (rt_o==instruction[25:21] | rt_o==instruction[20:16]). Combinational.
//  - ID/EX update priority each posedge: flush > stall > normal.
//    flush or stall or !in_valid: out_valid=0, all controls and illegal_o=0
//    (bubble); data fields don't-care but must not create writes.
//    normal: out_valid=1, load decoded controls and data.
//  - Stall lasts exactly one cycle per lw (bubble clears m_mem_read_o).
//  - flush and stall together: bubble, stall_out still asserted that cycle.
//  - Reset mid-operation: pipeline contents discarded, regfile cleared; first
//    post-reset instruction decodes normally.
//  - imm_ext = {{(B-IMM){instr[IMM-1]}}, instr[IMM-1:0]}.
// TESTING
//  1 Reset: assert reset async mid-cycle -> all outputs 0 immediately; regfile reads 0.
//  2 WB $5<=0x1234 then add $3,$5,$0 -> reg_data1=0x1234, reg_data2=0, ALUOp=10, RegDst=1.
//  3 Same-cycle WB $7<=0xCAFE while decoding addi $2,$7,-4 -> reg_data1=0xCAFE,
//    imm_ext=0xFFFFFFFC, ALUSrc=1.
//  4 lw $8,0($1) then add $9,$8,$2 -> stall_out=1 one cycle, one bubble (out_valid=0),
//    add then issues with rs=8; lw then add $9,$0,$0 with lw to $0 -> no stall.
//  5 Write to $0 with 0xFFFF -> later reads of $0 return 0.
//  6 flush with valid beq -> out_valid=0, m_branch_o=0; opcode 111111 -> illegal_o=1,
//    all controls 0.

Source files
------------

// File: rtl/id_stage_pipelined.sv
// MIPS instruction-decode stage: decode, register-file read with WB write-through,
// immediate sign-extension, load-use stall detection and the ID/EX pipeline register.
module id_stage_pipelined #(
  parameter int B   = 32,
  parameter int W   = 5,
  parameter int IMM = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [B-1:0] instruction,
  input  logic         flush,
  input  logic         wb_reg_write,
  input  logic [W-1:0] wb_addr,
  input  logic [B-1:0] wb_data,
  output logic         stall_out,
  output logic         out_valid,
  output logic [B-1:0] reg_data1,
  output logic [B-1:0] reg_data2,
  output logic [B-1:0] imm_ext,
  output logic [W-1:0] rs,
  output logic [W-1:0] rt,
  output logic [W-1:0] rd,
  output logic         wb_reg_write_o,
  output logic         wb_mem_to_reg_o,
  output logic         m_branch_o,
  output logic         m_mem_read_o,
  output logic         m_mem_write_o,
  output logic         ex_reg_dst_o,
  output logic         ex_alu_src_o,
  output logic [1:0]   ex_alu_op_o,
  output logic         illegal_o
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam int DEPTH = 2 ** W;

  logic [B-1:0] regs [DEPTH];

  logic [5:0]   opcode;
  logic [W-1:0] rs_addr;
  logic [W-1:0] rt_addr;
  logic [W-1:0] rd_addr;

  assign opcode  = instruction[31:26];
  assign rs_addr = instruction[25:21];
  assign rt_addr = instruction[20:16];
  assign rd_addr = instruction[15:11];

  logic         dec_reg_write;
  logic         dec_mem_to_reg;
  logic         dec_branch;
  logic         dec_mem_read;
  logic         dec_mem_write;
  logic         dec_reg_dst;
  logic         dec_alu_src;
  logic [1:0]   dec_alu_op;
  logic         dec_illegal;

  always_comb begin
    dec_reg_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_branch     = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_reg_dst    = 1'b0;
    dec_alu_src    = 1'b0;
    dec_alu_op     = ALU_ADD;
    dec_illegal    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_reg_write = 1'b1;
        dec_reg_dst   = 1'b1;
        dec_alu_op    = ALU_FUNCT;
      end
      OP_LW: begin
        dec_reg_write  = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_mem_read   = 1'b1;
        dec_alu_src    = 1'b1;
      end
      OP_SW: begin
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
      end
      OP_BEQ: begin
        dec_branch = 1'b1;
        dec_alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // A write landing this cycle is visible to the instruction being decoded now.
  logic         wb_active;
  logic [B-1:0] rd_data1;
  logic [B-1:0] rd_data2;

  assign wb_active = wb_reg_write && (wb_addr != '0);

  always_comb begin
    if (rs_addr == '0)
      rd_data1 = '0;
    else if (wb_active && (wb_addr == rs_addr))
      rd_data1 = wb_data;
    else
      rd_data1 = regs[rs_addr];

    if (rt_addr == '0)
      rd_data2 = '0;
    else if (wb_active && (wb_addr == rt_addr))
      rd_data2 = wb_data;
    else
      rd_data2 = regs[rt_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (wb_active) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Load-use: the lw now in ID/EX targets a source of the instruction in IF/ID.
  assign stall_out = in_valid && out_valid && m_mem_read_o && (rt != '0) &&
                     ((rt == rs_addr) || (rt == rt_addr));

  logic issue;
  assign issue = in_valid && !flush && !stall_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid       <= 1'b0;
      reg_data1       <= '0;
      reg_data2       <= '0;
      imm_ext         <= '0;
      rs              <= '0;
      rt              <= '0;
      rd              <= '0;
      wb_reg_write_o  <= 1'b0;
      wb_mem_to_reg_o <= 1'b0;
      m_branch_o      <= 1'b0;
      m_mem_read_o    <= 1'b0;
      m_mem_write_o   <= 1'b0;
      ex_reg_dst_o    <= 1'b0;
      ex_alu_src_o    <= 1'b0;
      ex_alu_op_o     <= ALU_ADD;
      illegal_o       <= 1'b0;
    end else begin
      reg_data1 <= rd_data1;
      reg_data2 <= rd_data2;
      imm_ext   <= {{(B-IMM){instruction[IMM-1]}}, instruction[IMM-1:0]};
      rs        <= rs_addr;
      rt        <= rt_addr;
      rd        <= rd_addr;
      if (issue) begin
        out_valid       <= 1'b1;
        wb_reg_write_o  <= dec_reg_write;
        wb_mem_to_reg_o <= dec_mem_to_reg;
        m_branch_o      <= dec_branch;
        m_mem_read_o    <= dec_mem_read;
        m_mem_write_o   <= dec_mem_write;
        ex_reg_dst_o    <= dec_reg_dst;
        ex_alu_src_o    <= dec_alu_src;
        ex_alu_op_o     <= dec_alu_op;
        illegal_o       <= dec_illegal;
      end else begin
        out_valid       <= 1'b0;
        wb_reg_write_o  <= 1'b0;
        wb_mem_to_reg_o <= 1'b0;
        m_branch_o      <= 1'b0;
        m_mem_read_o    <= 1'b0;
        m_mem_write_o   <= 1'b0;
        ex_reg_dst_o    <= 1'b0;
        ex_alu_src_o    <= 1'b0;
        ex_alu_op_o     <= ALU_ADD;
        illegal_o       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed bench for id_stage_pipelined: decode, bypass, load-use stall, flush, reset.
module tb_id_stage_pipelined;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] instruction;
  logic        flush;
  logic        wb_reg_write;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall_out;
  logic        out_valid;
  logic [31:0] reg_data1;
  logic [31:0] reg_data2;
  logic [31:0] imm_ext;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        wb_reg_write_o;
  logic        wb_mem_to_reg_o;
  logic        m_branch_o;
  logic        m_mem_read_o;
  logic        m_mem_write_o;
  logic        ex_reg_dst_o;
  logic        ex_alu_src_o;
  logic [1:0]  ex_alu_op_o;
  logic        illegal_o;

  int n_checks = 0;
  int n_fails  = 0;

  id_stage_pipelined dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .instruction(instruction),
    .flush(flush), .wb_reg_write(wb_reg_write), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall_out(stall_out), .out_valid(out_valid), .reg_data1(reg_data1),
    .reg_data2(reg_data2), .imm_ext(imm_ext), .rs(rs), .rt(rt), .rd(rd),
    .wb_reg_write_o(wb_reg_write_o), .wb_mem_to_reg_o(wb_mem_to_reg_o),
    .m_branch_o(m_branch_o), .m_mem_read_o(m_mem_read_o), .m_mem_write_o(m_mem_write_o),
    .ex_reg_dst_o(ex_reg_dst_o), .ex_alu_src_o(ex_alu_src_o),
    .ex_alu_op_o(ex_alu_op_o), .illegal_o(illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed control word: {rw, m2r, br, mr, mw, rdst, asrc, aop[1:0], ill}
  function automatic logic [31:0] ctl();
    return {22'd0, wb_reg_write_o, wb_mem_to_reg_o, m_branch_o, m_mem_read_o,
            m_mem_write_o, ex_reg_dst_o, ex_alu_src_o, ex_alu_op_o, illegal_o};
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; instruction = '0; flush = 1'b0;
    wb_reg_write = 1'b0; wb_addr = '0; wb_data = '0;
    #12;
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_stall", {31'd0, stall_out}, 32'd0);
    chk("reset_ctl", ctl(), 32'd0);
    @(negedge clk); reset = 1'b0;
    tick();

    // WB $5 <= 0x1234, then add $3,$5,$0
    wb_reg_write = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
    tick();
    wb_reg_write = 1'b0;
    in_valid = 1'b1; instruction = 32'h00A01820;
    tick();
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_rd1", reg_data1, 32'h1234);
    chk("add_rd2", reg_data2, 32'h0);
    chk("add_ctl", ctl(), 32'b1_0_0_0_0_1_0_10_0);
    chk("add_rd", {27'd0, rd}, 32'd3);

    // Same-cycle WB $7 <= 0xCAFE with addi $2,$7,-4
    wb_reg_write = 1'b1; wb_addr = 5'd7; wb_data = 32'hCAFE;
    instruction = 32'h20E2FFFC;
    tick();
    chk("addi_rd1_bypass", reg_data1, 32'hCAFE);
    chk("addi_imm", imm_ext, 32'hFFFFFFFC);
    chk("addi_ctl", ctl(), 32'b1_0_0_0_0_0_1_00_0);
    chk("addi_rt", {27'd0, rt}, 32'd2);
    wb_reg_write = 1'b0;
    instruction = 32'h00E02020;
    tick();
    chk("reg7_stored", reg_data1, 32'hCAFE);

    // lw $8,0($1) then add $9,$8,$2: one stall, one bubble
    instruction = 32'h8C280000;
    #1 chk("lw_no_stall", {31'd0, stall_out}, 32'd0);
    tick();
    chk("lw_ctl", ctl(), 32'b1_1_0_1_0_0_1_00_0);
    instruction = 32'h01024820;
    #1 chk("lu_stall", {31'd0, stall_out}, 32'd1);
    tick();
    chk("lu_bubble_valid", {31'd0, out_valid}, 32'd0);
    chk("lu_bubble_ctl", ctl(), 32'd0);
    #1 chk("lu_stall_released", {31'd0, stall_out}, 32'd0);
    tick();
    chk("lu_issue_valid", {31'd0, out_valid}, 32'd1);
    chk("lu_issue_rs", {27'd0, rs}, 32'd8);
    chk("lu_issue_rd", {27'd0, rd}, 32'd9);

    // lw to $0 never stalls
    instruction = 32'h8C200000;
    tick();
    chk("lw0_memread", {31'd0, m_mem_read_o}, 32'd1);
    instruction = 32'h00004820;
    #1 chk("lw0_no_stall", {31'd0, stall_out}, 32'd0);
    tick();
    chk("lw0_add_valid", {31'd0, out_valid}, 32'd1);

    // Writes to $0 are ignored, including the bypass path
    wb_reg_write = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
    instruction = 32'h00001820;
    tick();
    chk("r0_bypass", reg_data1, 32'h0);
    wb_reg_write = 1'b0;
    tick();
    chk("r0_read", reg_data1, 32'h0);

    // Flush squashes beq; then beq issues; then illegal opcode
    instruction = 32'h10220008; flush = 1'b1;
    tick();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_branch", {31'd0, m_branch_o}, 32'd0);
    flush = 1'b0;
    tick();
    chk("beq_ctl", ctl(), 32'b0_0_1_0_0_0_0_01_0);
    chk("beq_imm", imm_ext, 32'h8);
    instruction = 32'hFC000000;
    tick();
    chk("ill_valid", {31'd0, out_valid}, 32'd1);
    chk("ill_ctl", ctl(), 32'b0_0_0_0_0_0_0_00_1);

    // sw decode
    instruction = 32'hAC280010;
    tick();
    chk("sw_ctl", ctl(), 32'b0_0_0_0_1_0_1_00_0);

    // flush and stall together
    instruction = 32'h8C280000;
    tick();
    instruction = 32'h01024820; flush = 1'b1;
    #1 chk("flush_stall_out", {31'd0, stall_out}, 32'd1);
    tick();
    chk("flush_stall_bubble", {31'd0, out_valid}, 32'd0);
    flush = 1'b0;

    // in_valid low gives a bubble
    in_valid = 1'b0;
    tick();
    chk("idle_bubble", {31'd0, out_valid}, 32'd0);

    // Async reset mid-cycle with a lw in ID/EX
    in_valid = 1'b1; instruction = 32'h8C280000;
    tick();
    chk("pre_reset_memread", {31'd0, m_mem_read_o}, 32'd1);
    #1 reset = 1'b1;
    #1 chk("mid_reset_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_reset_ctl", ctl(), 32'd0);
    chk("mid_reset_stall", {31'd0, stall_out}, 32'd0);
    @(negedge clk); reset = 1'b0;
    instruction = 32'h00A01820;
    tick();
    chk("post_reset_valid", {31'd0, out_valid}, 32'd1);
    chk("post_reset_reg5", reg_data1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
